// File: rtl/lanectrl_pause_pkg.sv
// Shared definitions for the multi-lane HS_IO_CLK_PAUSE synchroniser:
// lane FSM state encodings, legal parameter ranges and sizing helpers.
package lanectrl_pause_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ASSERT = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  localparam int SYNC_STAGES_MIN = 1;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int MIN_PULSE_MIN   = 1;
  localparam int MIN_PULSE_MAX   = 16;
  localparam int HOLDOFF_MIN     = 0;
  localparam int HOLDOFF_MAX     = 15;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Bits needed to hold a down-counter that starts at max_val, never below 1.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/lanectrl_pause_lane.sv
// One pause lane: input synchroniser, pulse-shaping FSM with minimum high
// time and holdoff gap, sticky missed-request flag, optional negedge retime.
module lanectrl_pause_lane
  import lanectrl_pause_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 2,
  parameter int HOLDOFF     = 1,
  parameter int FALL_OUT    = 0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic pause_i,
  input  logic lane_en_i,
  output logic pause_sync_o,
  output logic missed_o
);

  localparam int PW = cnt_width(MIN_PULSE - 1);
  localparam int GW = cnt_width(HOLDOFF);
  localparam logic [PW-1:0] PCNT_INIT = PW'(MIN_PULSE - 1);
  localparam logic [GW-1:0] GCNT_INIT = (HOLDOFF > 0) ? GW'(HOLDOFF - 1) : '0;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [PW-1:0]          pcnt_q, pcnt_d;
  logic [GW-1:0]          gcnt_q, gcnt_d;
  logic                   pend_q, pend_d;
  logic                   missed_q, missed_d;
  logic                   s;
  logic                   assert_w;

  always_comb begin
    sync_d    = '0;
    sync_d[0] = pause_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    pcnt_d   = pcnt_q;
    gcnt_d   = gcnt_q;
    pend_d   = pend_q;
    missed_d = missed_q;
    case (state_q)
      ST_IDLE: begin
        if (s && lane_en_i) begin
          state_d = ST_ASSERT;
          pcnt_d  = PCNT_INIT;
        end
      end
      ST_ASSERT: begin
        // A held request keeps the lane asserted once the minimum width is met.
        if (pcnt_q != '0) begin
          pcnt_d = pcnt_q - PW'(1);
        end else if (!s) begin
          if (HOLDOFF == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            gcnt_d  = GCNT_INIT;
          end
        end
      end
      ST_GAP: begin
        if (s) pend_d = 1'b1;
        if (gcnt_q != '0) begin
          gcnt_d = gcnt_q - GW'(1);
        end else begin
          pend_d = 1'b0;
          if (pend_q && !s) missed_d = 1'b1;
          if (s && lane_en_i) begin
            state_d = ST_ASSERT;
            pcnt_d  = PCNT_INIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q   <= '0;
      state_q  <= ST_IDLE;
      pcnt_q   <= '0;
      gcnt_q   <= '0;
      pend_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      gcnt_q   <= gcnt_d;
      pend_q   <= pend_d;
      missed_q <= missed_d;
    end
  end

  assign assert_w = (state_q == ST_ASSERT);
  assign missed_o = missed_q;

  if (FALL_OUT != 0) begin : g_fall
    logic out_q;
    always_ff @(negedge CLK or posedge RESET) begin
      if (RESET) out_q <= 1'b0;
      else       out_q <= assert_w;
    end
    assign pause_sync_o = out_q;
  end else begin : g_rise
    assign pause_sync_o = assert_w;
  end

endmodule

// File: rtl/lanectrl_pause_sync_multi.sv
// Multi-lane pause synchroniser between PHY training/control and the lane
// controllers' HS_IO_CLK_PAUSE inputs; lanes are fully independent.
module lanectrl_pause_sync_multi
  import lanectrl_pause_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 2,
  parameter int HOLDOFF     = 1,
  parameter int FALL_OUT    = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_LANES-1:0] PAUSE_IN,
  input  logic [NUM_LANES-1:0] LANE_EN,
  output logic [NUM_LANES-1:0] PAUSE_SYNC,
  output logic                 PAUSE_ANY,
  output logic [NUM_LANES-1:0] PAUSE_MISSED
);

  // Out-of-range settings are pulled back to the nearest legal value.
  localparam int SYNC_N  = clamp_int(SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  localparam int PULSE_N = clamp_int(MIN_PULSE, MIN_PULSE_MIN, MIN_PULSE_MAX);
  localparam int HOLD_N  = clamp_int(HOLDOFF, HOLDOFF_MIN, HOLDOFF_MAX);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    lanectrl_pause_lane #(
      .SYNC_STAGES(SYNC_N),
      .MIN_PULSE  (PULSE_N),
      .HOLDOFF    (HOLD_N),
      .FALL_OUT   (FALL_OUT)
    ) u_lane (
      .CLK         (CLK),
      .RESET       (RESET),
      .pause_i     (PAUSE_IN[gi]),
      .lane_en_i   (LANE_EN[gi]),
      .pause_sync_o(PAUSE_SYNC[gi]),
      .missed_o    (PAUSE_MISSED[gi])
    );
  end

  assign PAUSE_ANY = |PAUSE_SYNC;

endmodule

// File: doc/lanectrl_pause_sync_multi.md
Name: lanectrl_pause_sync_multi

Overview:
Parametrised multi-lane successor to the single-lane HS_IO_CLK_PAUSE synchroniser. It synchronises NUM_LANES asynchronous pause requests into the CLK domain through a configurable-depth flop chain. Each lane applies a guaranteed minimum assertion width and a minimum de-assertion gap, and can optionally retime its output on the falling edge. It sits between the DDR PHY training/control logic and the lane controllers' HS_IO_CLK_PAUSE inputs, and reports lost requests.

Parameters:
NUM_LANES, 4, number of independent pause lanes (1..16)
SYNC_STAGES, 2, synchroniser flops per lane (1..4)
MIN_PULSE, 2, minimum PAUSE_SYNC high time in CLK cycles (1..16)
HOLDOFF, 1, minimum PAUSE_SYNC low time between pulses in CLK cycles (0..15)
FALL_OUT, 0, 1 = final output flop clocked on negedge CLK (adds half cycle)

Ports:
CLK  input  1  lane controller clock
RESET  input  1  reset
PAUSE_IN  input  NUM_LANES  asynchronous pause requests, one per lane
LANE_EN  input  NUM_LANES  per-lane enable; gates only new pulse starts
PAUSE_SYNC  output  NUM_LANES  synchronised, shaped pause per lane
PAUSE_ANY  output  1  OR of all PAUSE_SYNC bits (combinational from output flops)
PAUSE_MISSED  output  NUM_LANES  sticky flag: a request was swallowed by a holdoff gap

Behaviour:
- Reset RESET, asynchronous, active-high; clock CLK. All sync flops, FSMs, counters, PAUSE_SYNC, PAUSE_MISSED (and the negedge flop) clear to 0 immediately on RESET.
- Sync chain: s = PAUSE_IN after SYNC_STAGES posedge flops.
- Per-lane FSM, states IDLE / ASSERT / GAP; registered; PAUSE_SYNC = (state==ASSERT).
  - IDLE: if s & LANE_EN, go to ASSERT with pcnt=MIN_PULSE-1.
  - ASSERT: if pcnt>0, pcnt--. If pcnt==0 & !s, go to GAP with gcnt=HOLDOFF-1, or to IDLE if HOLDOFF==0. s high keeps the lane in ASSERT indefinitely.
  - GAP: gcnt-- while gcnt>0. At gcnt==0: if s & LANE_EN go to ASSERT (reload pcnt), else go to IDLE.
  - pend flag: set when s==1 in GAP. At GAP exit, if pend & !s, set PAUSE_MISSED[lane]. pend clears on GAP exit. PAUSE_MISSED clears only on RESET.
- Latency: PAUSE_SYNC rises SYNC_STAGES+1 posedges after the PAUSE_IN rise is first sampled. The fall follows the same latency unless the stretch is active. FALL_OUT=1 adds a half cycle to both edges.
- High time = max(MIN_PULSE, synchronised input high time). Low time between pulses >= HOLDOFF (HOLDOFF=0 gives >= 1 cycle via IDLE).
- LANE_EN deasserted mid-ASSERT: the current pulse completes normally. LANE_EN low in IDLE: the request is ignored and not flagged missed.
- Lanes are fully independent; simultaneous events on different lanes do not interact.
- Counter widths: clog2(MIN_PULSE) and clog2(HOLDOFF+1), minimum 1 bit each; no wrap (decrement saturates at 0).

Decomposition:
- Package lanectrl_pause_pkg: state enum (IDLE/ASSERT/GAP), parameter-range limits, width helper function.
- Sub-module lanectrl_pause_lane: one lane (sync chain, FSM, counters, missed flag, optional negedge flop).
- Top: generate NUM_LANES instances plus the PAUSE_ANY OR reduction.

Test Plan:
- Defaults except MIN_PULSE=3, HOLDOFF=2: 1-cycle PAUSE_IN on lane0 -> PAUSE_SYNC[0] rises 3 posedges later, stays high exactly 3 cycles, PAUSE_ANY mirrors it, other lanes stay 0.
- 10-cycle PAUSE_IN on lane1 -> PAUSE_SYNC[1] high exactly 10 cycles, delayed 3 cycles; PAUSE_MISSED stays 0.
- Lane2 pulse, then a 1-cycle request landing inside the 2-cycle GAP -> no second pulse; PAUSE_MISSED[2]=1 and it remains 1 until RESET.
- Lane3 request held high across the GAP -> second pulse starts exactly 2 cycles after the first falls.
- LANE_EN[0]=0 with PAUSE_IN[0] pulsed -> PAUSE_SYNC[0]=0, PAUSE_MISSED[0]=0. Deassert LANE_EN mid-pulse -> the pulse completes its full 3 cycles.
- RESET asserted mid-ASSERT on all lanes -> PAUSE_SYNC, PAUSE_ANY and PAUSE_MISSED go 0 immediately. FALL_OUT=1 build -> edges shift by half a CLK period.
